cdb_arbiter: RTL

- Owns one common data bus (CDB) instance, either the GPR bus or the FPR bus. It shares that bus between variable-latency producers and one fixed-latency pipeline.
- Variable-latency producers (load unit, ALU, etc.) use the req_if valid/ready style. Each is granted in round-robin order and drives the bus the cycle after its grant.
- The fixed-latency pipeline (FPU) reserves a bus slot a known number of cycles ahead and is never stalled.
- CDB outputs go to every reservation station, the ROB and the load/store unit.

---
 rtl/cdb_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus between round-robin requesters and a
// fixed-latency unit that reserves slots ahead of time and is never stalled.
module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_LAT   = 8,
    parameter int ROB_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [ROB_WIDTH-1:0]         src_tag [N_REQ],
    input  logic [31:0]                  src_data [N_REQ],
    input  logic                         rsv_valid,
    input  logic [$clog2(MAX_LAT+1)-1:0] rsv_lat,
    output logic                         rsv_ready,
    input  logic [ROB_WIDTH-1:0]         fix_tag,
    input  logic [31:0]                  fix_data,
    output logic                         cdb_valid,
    output logic [ROB_WIDTH-1:0]         cdb_tag,
    output logic [31:0]                  cdb_data
);
    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [MAX_LAT:1]  busy, busy_nxt;
    logic [2**LW-1:0]  busy_ext;
    logic [IW-1:0]     rr_ptr, win, sel_q;
    logic              fix_q, cdb_valid_q;
    logic              rsv_ok, rsv1, free, found, grant;

    // Lead 0 and leads beyond MAX_LAT look permanently busy, so they are never accepted.
    always_comb begin
        busy_ext = '1;
        busy_ext[MAX_LAT:1] = busy;
    end

    assign rsv_ok    = reset && rsv_valid && !busy_ext[rsv_lat];
    assign rsv_ready = rsv_ok;
    assign rsv1      = rsv_ok && rsv_lat == LW'(1);
    assign free      = !busy[1] && !rsv1;

    always_comb begin
        busy_nxt = '0;
        for (int k = 1; k < MAX_LAT; k++)
            busy_nxt[k] = busy[k+1] | (rsv_ok && rsv_lat == LW'(k + 1));
    end

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        for (int j = 1; j <= N_REQ; j++)
            if (!found && req_valid[(int'(rr_ptr) + j) % N_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(rr_ptr) + j) % N_REQ);
            end
    end

    assign grant     = reset && free && found;
    assign req_ready = grant ? N_REQ'(1) << win : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= '0;
            rr_ptr      <= IW'(N_REQ - 1);
            sel_q       <= '0;
            fix_q       <= 1'b0;
            cdb_valid_q <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            if (grant)
                rr_ptr  <= win;
            sel_q       <= win;
            fix_q       <= busy[1] | rsv1;
            cdb_valid_q <= grant | busy[1] | rsv1;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = fix_q ? fix_tag  : src_tag[sel_q];
    assign cdb_data  = fix_q ? fix_data : src_data[sel_q];
endmodule
